// File: rtl/spi_link_pkg.sv
// Shared definitions for the SPI command router: opcode values and FSM states.
package spi_link_pkg;

    localparam logic [7:0] OP_SET_CH  = 8'h87;
    localparam logic [7:0] OP_STREAM  = 8'h88;
    localparam logic [7:0] OP_REG     = 8'h89;
    localparam logic [7:0] OP_FIFO_RD = 8'h8A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_CH,
        ST_SET_VAL,
        ST_STRM_CH,
        ST_STRM_LEN,
        ST_STRM_DATA,
        ST_REG_ADDR,
        ST_REG_WR,
        ST_REG_CNT,
        ST_REG_RD,
        ST_FIFO_CNT,
        ST_FIFO_RD
    } state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// One-entry output register backed by a one-entry skid register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data, in_push    byte/word offered this cycle
//   in_drop             combinational: push arrived with both entries full
//   out_data, out_valid output register contents
//   out_ready           downstream accepts out_data when out_valid is high
module stream_skid_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_push,
    output logic              in_drop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;
    logic              fire;

    assign fire    = out_valid && out_ready;
    // A handshake this cycle frees a slot, so only a full buffer with no fire drops.
    assign in_drop = in_push && out_valid && skid_valid && !fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (fire) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                skid_valid <= in_push;
                if (in_push) begin
                    skid_data <= in_data;
                end
            end else if (in_push) begin
                out_data <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_push) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else if (!skid_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_router.sv
// SPI command decoder between the SPI byte slave and the fabric.
// Decodes SET_CH, STREAM, REG (burst read/write) and FIFO_RD frames.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rx_data, rx_valid, cs_idle    received byte, strobe, frame abort
//   tx_data, tx_load              read byte for the SPI slave, 1-cycle strobe
//   ch_value                      per-channel value registers, ch0 in [7:0]
//   strm_*                        stream ready/valid output with channel/last
//   reg_addr/wdata/we, reg_rdata  register bus (rdata combinational from addr)
//   fifo_rd, fifo_data, fifo_empty FWFT FIFO read port
//   err_ovf, err_unf, busy        stream drop, FIFO underflow, frame active
module spi_cmd_router
    import spi_link_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned LEN_W  = 16,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                cs_idle,
    output logic [7:0]          tx_data,
    output logic                tx_load,
    output logic [NUM_CH*8-1:0] ch_value,
    output logic [7:0]          strm_data,
    output logic [CH_W-1:0]     strm_ch,
    output logic                strm_last,
    output logic                strm_valid,
    input  logic                strm_ready,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic [7:0]          reg_wdata,
    output logic                reg_we,
    input  logic [7:0]          reg_rdata,
    output logic                fifo_rd,
    input  logic [7:0]          fifo_data,
    input  logic                fifo_empty,
    output logic                err_ovf,
    output logic                err_unf,
    output logic                busy
);

    localparam int unsigned LEN_BYTES = LEN_W / 8;
    localparam int unsigned SB_W      = 8 + CH_W + 1;

    state_t            state;
    logic [7:0]        ch_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              len_idx;
    logic [ADDR_W-1:0] addr_q;
    logic              ch_ok;
    logic              strm_push;
    logic              strm_drop;
    logic [SB_W-1:0]   sb_in;
    logic [SB_W-1:0]   sb_out;

    assign ch_ok     = {1'b0, ch_q} < 9'(NUM_CH);
    assign strm_push = rx_valid && !cs_idle && (state == ST_STRM_DATA) && ch_ok;
    assign sb_in     = {(cnt_q == '0), ch_q[CH_W-1:0], rx_data};

    assign {strm_last, strm_ch, strm_data} = sb_out;
    assign reg_addr = addr_q;
    assign busy     = (state != ST_IDLE);

    stream_skid_buf #(
        .DATA_W(SB_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (sb_in),
        .in_push   (strm_push),
        .in_drop   (strm_drop),
        .out_data  (sb_out),
        .out_valid (strm_valid),
        .out_ready (strm_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            len_idx   <= 1'b0;
            addr_q    <= '0;
            ch_value  <= '0;
            tx_data   <= '0;
            tx_load   <= 1'b0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            fifo_rd   <= 1'b0;
            err_unf   <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            reg_we  <= 1'b0;
            fifo_rd <= 1'b0;
            err_unf <= 1'b0;
            err_ovf <= strm_drop;
            // Write address advances once the strobe has been presented with it,
            // so reg_addr stays combinationally valid for both reads and writes.
            if (reg_we) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (cs_idle) begin
                state <= ST_IDLE;
            end else if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        case (rx_data)
                            OP_SET_CH:  state <= ST_SET_CH;
                            OP_STREAM:  state <= ST_STRM_CH;
                            OP_REG:     state <= ST_REG_ADDR;
                            OP_FIFO_RD: state <= ST_FIFO_CNT;
                            default:    state <= ST_IDLE;
                        endcase
                    end
                    ST_SET_CH: begin
                        ch_q  <= rx_data;
                        state <= ST_SET_VAL;
                    end
                    ST_SET_VAL: begin
                        if (ch_ok) begin
                            ch_value[{ch_q[CH_W-1:0], 3'b000} +: 8] <= rx_data;
                        end
                        state <= ST_IDLE;
                    end
                    ST_STRM_CH: begin
                        ch_q    <= rx_data;
                        len_idx <= 1'b0;
                        state   <= ST_STRM_LEN;
                    end
                    ST_STRM_LEN: begin
                        if (!len_idx) begin
                            cnt_q[7:0] <= rx_data;
                        end else begin
                            cnt_q[LEN_W-1 -: 8] <= rx_data;
                        end
                        if (len_idx == 1'(LEN_BYTES - 1)) begin
                            state <= ST_STRM_DATA;
                        end else begin
                            len_idx <= 1'b1;
                        end
                    end
                    ST_STRM_DATA: begin
                        if (cnt_q == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end
                    ST_REG_ADDR: begin
                        addr_q <= rx_data[ADDR_W-1:0];
                        state  <= rx_data[7] ? ST_REG_WR : ST_REG_CNT;
                    end
                    ST_REG_WR: begin
                        reg_wdata <= rx_data;
                        reg_we    <= 1'b1;
                    end
                    ST_REG_CNT: begin
                        cnt_q <= LEN_W'(rx_data);
                        state <= ST_REG_RD;
                    end
                    ST_REG_RD: begin
                        tx_data <= reg_rdata;
                        tx_load <= 1'b1;
                        addr_q  <= addr_q + ADDR_W'(1);
                        if (cnt_q == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end
                    ST_FIFO_CNT: begin
                        cnt_q <= LEN_W'(rx_data);
                        state <= ST_FIFO_RD;
                    end
                    ST_FIFO_RD: begin
                        tx_data <= fifo_empty ? 8'h00 : fifo_data;
                        tx_load <= 1'b1;
                        fifo_rd <= !fifo_empty;
                        err_unf <= fifo_empty;
                        if (cnt_q == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_router.sv
// Scoreboard bench for spi_cmd_router: directed frames push expected tx bytes,
// register writes and stream beats into queues; a negedge monitor pops and compares.
module tb_spi_cmd_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cs_idle;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic [31:0] ch_value;
    logic [7:0]  strm_data;
    logic [1:0]  strm_ch;
    logic        strm_last;
    logic        strm_valid;
    logic        strm_ready;
    logic [6:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic [7:0]  reg_rdata;
    logic        fifo_rd;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        err_ovf;
    logic        err_unf;
    logic        busy;

    always #5 clk = ~clk;

    // Register file and FIFO models (preloaded by the stimulus process only).
    logic [7:0] regs [128];
    logic [7:0] fifo_mem [4];
    int         fifo_loaded = 0;
    int         fifo_pops = 0;

    assign reg_rdata  = regs[reg_addr];
    assign fifo_empty = (fifo_pops >= fifo_loaded);
    assign fifo_data  = fifo_mem[fifo_pops[1:0]];

    always @(posedge clk) begin
        if (fifo_rd) fifo_pops <= fifo_pops + 1;
    end

    spi_cmd_router #(
        .NUM_CH (4),
        .ADDR_W (7),
        .LEN_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cs_idle    (cs_idle),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .ch_value   (ch_value),
        .strm_data  (strm_data),
        .strm_ch    (strm_ch),
        .strm_last  (strm_last),
        .strm_valid (strm_valid),
        .strm_ready (strm_ready),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_rdata  (reg_rdata),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  exp_tx[$];
    logic [14:0] exp_wr[$];    // {addr, data}
    logic [10:0] exp_strm[$];  // {ch, last, data}
    int ovf_seen = 0;
    int unf_seen = 0;
    int rd_seen  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_load && reg_we) check("tx_we_exclusive", 32'({tx_load, reg_we}), 32'b10);
            if (tx_load) begin
                if (exp_tx.size() == 0) check("tx_unexpected", 32'(exp_tx.size()), 32'd1);
                else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
            if (reg_we) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 32'(exp_wr.size()), 32'd1);
                else check("reg_write", 32'({reg_addr, reg_wdata}), 32'(exp_wr.pop_front()));
            end
            if (strm_valid && strm_ready) begin
                if (exp_strm.size() == 0) check("strm_unexpected", 32'(exp_strm.size()), 32'd1);
                else check("strm_beat", 32'({strm_ch, strm_last, strm_data}), 32'(exp_strm.pop_front()));
            end
            if (err_ovf) ovf_seen++;
            if (err_unf) unf_seen++;
            if (fifo_rd) rd_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic pulse_cs();
        @(posedge clk); #1;
        cs_idle = 1'b1;
        @(posedge clk); #1;
        cs_idle = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    int ovf0, unf0, rd0;

    initial begin
        rst        = 1'b1;
        rx_data    = '0;
        rx_valid   = 1'b0;
        cs_idle    = 1'b0;
        strm_ready = 1'b0;
        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        for (int i = 0; i < 4; i++) fifo_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pulses", 32'({tx_load, reg_we, fifo_rd, err_ovf, err_unf, busy, strm_valid}), 32'd0);
        check("rst_ch_value", ch_value, 32'h0);
        check("rst_data", 32'({tx_data, reg_wdata, reg_addr}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // SET_CH in range, out of range, and a partial frame cut by cs_idle.
        send_frame('{8'h87, 8'h02, 8'h5A});
        @(negedge clk);
        check("set_ch2", ch_value, 32'h005A_0000);
        send_frame('{8'h87, 8'h07, 8'h11});
        @(negedge clk);
        check("set_ch_oor", ch_value, 32'h005A_0000);
        send_frame('{8'h87, 8'h03});
        pulse_cs();
        send_byte(8'h44);
        @(negedge clk);
        check("set_ch_partial", ch_value, 32'h005A_0000);
        check("busy_after_abort", 32'(busy), 32'd0);

        // STREAM with ready held high.
        strm_ready = 1'b1;
        exp_strm.push_back({2'd1, 1'b0, 8'hA0});
        exp_strm.push_back({2'd1, 1'b0, 8'hA1});
        exp_strm.push_back({2'd1, 1'b0, 8'hA2});
        exp_strm.push_back({2'd1, 1'b1, 8'hA3});
        send_frame('{8'h88, 8'h01, 8'h03, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3});
        @(negedge clk);
        check("strm_busy_drop", 32'(busy), 32'd0);
        check("strm_no_ovf", 32'(ovf_seen), 32'd0);

        // STREAM with ready low: A0 held, A1 in skid, A2/A3 dropped.
        strm_ready = 1'b0;
        ovf0 = ovf_seen;
        exp_strm.push_back({2'd1, 1'b0, 8'hA0});
        exp_strm.push_back({2'd1, 1'b0, 8'hA1});
        send_frame('{8'h88, 8'h01, 8'h03, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3});
        @(negedge clk);
        check("ovf_count", 32'(ovf_seen - ovf0), 32'd2);
        check("strm_held", 32'({strm_valid, strm_data}), 32'h1A0);
        @(posedge clk); #1;
        strm_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("strm_drained", 32'(exp_strm.size()), 32'd0);

        // REG burst read wrapping through the top of the address space.
        regs[7'h7E] = 8'hD1;
        regs[7'h7F] = 8'hD2;
        regs[7'h00] = 8'hD0;
        exp_tx.push_back(8'hD1);
        exp_tx.push_back(8'hD2);
        exp_tx.push_back(8'hD0);
        send_frame('{8'h89, 8'h7E, 8'h02, 8'h00, 8'h00, 8'h00});
        @(negedge clk);
        check("reg_rd_done", 32'({busy, 8'(exp_tx.size())}), 32'd0);

        // FIFO read of 4 bytes with only 2 entries available.
        fifo_mem[0] = 8'h31;
        fifo_mem[1] = 8'h32;
        unf0 = unf_seen;
        rd0  = rd_seen;
        fifo_loaded = 2;
        exp_tx.push_back(8'h31);
        exp_tx.push_back(8'h32);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
        send_frame('{8'h8A, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00});
        @(negedge clk);
        check("unf_count", 32'(unf_seen - unf0), 32'd2);
        check("fifo_rd_count", 32'(rd_seen - rd0), 32'd2);

        // REG write ended by cs_idle, then SET_CH ch0.
        exp_wr.push_back({7'h05, 8'hC1});
        send_frame('{8'h89, 8'h85, 8'hC1});
        pulse_cs();
        send_frame('{8'h87, 8'h00, 8'h33});
        @(negedge clk);
        check("ch0_after_write", ch_value, 32'h005A_0033);

        // Reset mid STREAM discards the held byte and clears ch_value.
        strm_ready = 1'b0;
        send_frame('{8'h88, 8'h00, 8'h03, 8'h00, 8'hB0});
        @(negedge clk);
        check("strm_pending", 32'({strm_valid, busy}), 32'b11);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_strm", 32'({strm_valid, busy}), 32'd0);
        check("rst_mid_ch_value", ch_value, 32'h0);
        strm_ready = 1'b1;
        send_frame('{8'h87, 8'h01, 8'h77});
        @(negedge clk);
        check("set_after_rst", ch_value, 32'h0000_7700);

        for (int i = 0; i < 100 && (exp_tx.size() + exp_wr.size() + exp_strm.size()) != 0; i++)
            @(posedge clk);
        @(negedge clk);
        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("strm_queue_empty", 32'(exp_strm.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
